// File: rtl/led_matrix_scan.sv
// 8x8 LED matrix row scanner: double-buffered frame, blanking gap, 8-level PWM.
// Ports: clk, rst (async active-low), game_display/enable/brightness in; row_sel/col_data/row_idx/frame_start out.
module led_matrix_scan #(
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] game_display,
  input  logic        enable,
  input  logic [2:0]  brightness,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_data,
  output logic [2:0]  row_idx,
  output logic        frame_start
);

  localparam int unsigned P    = BLANK_CYCLES + DWELL_CYCLES;
  localparam int unsigned SLOT = DWELL_CYCLES / 8;
  localparam int unsigned CW   = $clog2(P);

  localparam logic [CW-1:0] LAST_BLANK = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] LAST_DWELL = CW'(P - 1);

  // Phase of the cycle the next edge will present.
  typedef enum logic {
    ST_BLANK,
    ST_DWELL
  } state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  row_q, row_d;
  logic [63:0] shadow_q, shadow_d;
  logic [2:0]  bri_q, bri_d;
  logic [7:0]  row_sel_q, row_sel_d;
  logic [7:0]  col_q, col_d;
  logic [2:0]  row_idx_q, row_idx_d;
  logic        fs_q, fs_d;

  logic [7:0]  row_byte;
  logic [31:0] off_w;
  logic [31:0] thr_w;
  logic        pwm_on;

  assign row_byte = shadow_q[{row_q, 3'b000} +: 8];

  // Column on while the dwell offset is inside the first
  // (brightness+1) slots; avoids a divider.
  assign off_w  = 32'(cnt_q) - BLANK_CYCLES;
  assign thr_w  = (32'(bri_q) + 32'd1) * SLOT;
  assign pwm_on = off_w < thr_w;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    shadow_d  = shadow_q;
    bri_d     = bri_q;
    row_sel_d = 8'h00;
    col_d     = 8'h00;
    row_idx_d = 3'd0;
    fs_d      = 1'b0;
    if (!enable) begin
      state_d = ST_BLANK;
      cnt_d   = '0;
      row_d   = 3'd0;
    end else begin
      row_idx_d = row_q;
      unique case (state_q)
        ST_BLANK: begin
          if (cnt_q == '0) begin
            bri_d = brightness;
            if (row_q == 3'd0) begin
              shadow_d = game_display;
              fs_d     = 1'b1;
            end
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BLANK) begin
            state_d = ST_DWELL;
          end
        end
        ST_DWELL: begin
          row_sel_d = 8'b1 << row_q;
          col_d     = pwm_on ? row_byte : 8'h00;
          if (cnt_q == LAST_DWELL) begin
            cnt_d   = '0;
            row_d   = row_q + 1'b1;
            state_d = ST_BLANK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          row_d   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_BLANK;
      cnt_q     <= '0;
      row_q     <= 3'd0;
      shadow_q  <= 64'h0;
      bri_q     <= 3'd0;
      row_sel_q <= 8'h00;
      col_q     <= 8'h00;
      row_idx_q <= 3'd0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      shadow_q  <= shadow_d;
      bri_q     <= bri_d;
      row_sel_q <= row_sel_d;
      col_q     <= col_d;
      row_idx_q <= row_idx_d;
      fs_q      <= fs_d;
    end
  end

  assign row_sel     = row_sel_q;
  assign col_data    = col_q;
  assign row_idx     = row_idx_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Self-checking bench for led_matrix_scan against a frame-arithmetic model.
// DWELL=16, BLANK=2: row period 18, frame period 144.
module tb_led_matrix_scan;

  localparam int D = 16;
  localparam int B = 2;
  localparam int P = D + B;
  localparam int F = 8 * P;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] gd;
  logic        en;
  logic [2:0]  br;
  logic [7:0]  row_sel;
  logic [7:0]  col_data;
  logic [2:0]  row_idx;
  logic        frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          m_n;
  logic [63:0] m_sh;
  logic [2:0]  m_br;
  logic [7:0]  e_rs, e_cd;
  logic [2:0]  e_ri;
  logic        e_fs;

  led_matrix_scan #(
    .DWELL_CYCLES(D),
    .BLANK_CYCLES(B)
  ) dut (
    .clk(clk),
    .rst(rst),
    .game_display(gd),
    .enable(en),
    .brightness(br),
    .row_sel(row_sel),
    .col_data(col_data),
    .row_idx(row_idx),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and compute what it should show:
  // position in the frame from the edge count since enable.
  task automatic step();
    int k, r, c;
    @(posedge clk);
    if (!en) begin
      m_n  = 0;
      e_rs = 8'h00;
      e_cd = 8'h00;
      e_ri = 3'd0;
      e_fs = 1'b0;
    end else begin
      m_n = m_n + 1;
      k = (m_n - 1) % F;
      r = k / P;
      c = k % P;
      e_fs = (k == 0);
      if (k == 0) m_sh = gd;
      if (c == 0) m_br = br;
      e_ri = 3'(r);
      if (c < B) begin
        e_rs = 8'h00;
        e_cd = 8'h00;
      end else begin
        e_rs = 8'(1 << r);
        e_cd = (((c - B) / (D / 8)) <= int'(m_br)) ? m_sh[r*8 +: 8] : 8'h00;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst  = 1'b0;
    m_n  = 0;
    m_sh = '0;
    m_br = '0;
    e_rs = '0;
    e_cd = '0;
    e_ri = '0;
    e_fs = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    gd = {$urandom, $urandom};
    br = 3'd7;
    en = 1'b1;
    rst = 1'b0;
    #2;
    n_tests++;
    if ({row_sel, col_data, row_idx, frame_start} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_async: rs=%h cd=%h ri=%0d fs=%b want all 0",
               row_sel, col_data, row_idx, frame_start);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if ({row_sel, col_data, row_idx, frame_start} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_held: rs=%h cd=%h ri=%0d fs=%b want all 0",
               row_sel, col_data, row_idx, frame_start);
    end
    do_reset();
  endtask

  task automatic test_basic();
    gd = 64'h8040201008040201;
    br = 3'd7;
    en = 1'b1;
    do_reset();
    for (int n = 1; n <= 150; n++) begin
      step();
      n_tests++;
      if ({row_sel, col_data, row_idx, frame_start} !== {e_rs, e_cd, e_ri, e_fs}) begin
        n_fail++;
        $display("FAIL basic edge %0d: rs=%h cd=%h ri=%0d fs=%b want rs=%h cd=%h ri=%0d fs=%b",
                 n, row_sel, col_data, row_idx, frame_start, e_rs, e_cd, e_ri, e_fs);
      end
      if (n == 1 || n == 145) begin
        n_tests++;
        if (frame_start !== 1'b1) begin
          n_fail++;
          $display("FAIL basic_fs edge %0d: got %b want 1", n, frame_start);
        end
      end
      if (n == 2) begin
        n_tests++;
        if (row_sel !== 8'h00 || frame_start !== 1'b0) begin
          n_fail++;
          $display("FAIL basic_blank edge 2: rs=%h fs=%b want 00 0", row_sel, frame_start);
        end
      end
      if (n == 3 || n == 18) begin
        n_tests++;
        if (row_sel !== 8'h01 || col_data !== 8'h01) begin
          n_fail++;
          $display("FAIL basic_row0 edge %0d: rs=%h cd=%h want 01 01", n, row_sel, col_data);
        end
      end
      if (n == 21 || n == 36) begin
        n_tests++;
        if (row_sel !== 8'h02 || col_data !== 8'h02) begin
          n_fail++;
          $display("FAIL basic_row1 edge %0d: rs=%h cd=%h want 02 02", n, row_sel, col_data);
        end
      end
      n_tests++;
      if ($countones(row_sel) > 1) begin
        n_fail++;
        $display("FAIL onehot edge %0d: rs=%h want at most one bit", n, row_sel);
      end
    end
  endtask

  task automatic test_tear();
    logic [63:0] a;
    a  = {$urandom, $urandom};
    gd = a;
    br = 3'd7;
    en = 1'b1;
    do_reset();
    for (int n = 1; n <= 160; n++) begin
      if (n == 50) gd = '1;
      step();
      n_tests++;
      if ({row_sel, col_data, row_idx, frame_start} !== {e_rs, e_cd, e_ri, e_fs}) begin
        n_fail++;
        $display("FAIL tear edge %0d: rs=%h cd=%h ri=%0d fs=%b want rs=%h cd=%h ri=%0d fs=%b",
                 n, row_sel, col_data, row_idx, frame_start, e_rs, e_cd, e_ri, e_fs);
      end
      if (n == 100) begin
        n_tests++;
        if (col_data !== a[47:40]) begin
          n_fail++;
          $display("FAIL tear_old edge 100: cd=%h want %h", col_data, a[47:40]);
        end
      end
      if (n == 147) begin
        n_tests++;
        if (col_data !== 8'hFF) begin
          n_fail++;
          $display("FAIL tear_new edge 147: cd=%h want ff", col_data);
        end
      end
    end
  endtask

  task automatic test_pwm();
    int last_on;
    logic [2:0] lv [3];
    lv[0] = 3'd0;
    lv[1] = 3'd3;
    lv[2] = 3'd7;
    for (int i = 0; i < 3; i++) begin
      gd = {$urandom, $urandom};
      gd[7:0] = 8'hFF;
      br = lv[i];
      en = 1'b1;
      last_on = 3 + 2 * (int'(lv[i]) + 1) - 1;
      do_reset();
      for (int n = 1; n <= 40; n++) begin
        step();
        n_tests++;
        if ({row_sel, col_data, row_idx, frame_start} !== {e_rs, e_cd, e_ri, e_fs}) begin
          n_fail++;
          $display("FAIL pwm b=%0d edge %0d: rs=%h cd=%h want rs=%h cd=%h",
                   lv[i], n, row_sel, col_data, e_rs, e_cd);
        end
        if (n == last_on) begin
          n_tests++;
          if (col_data !== 8'hFF || row_sel !== 8'h01) begin
            n_fail++;
            $display("FAIL pwm_on b=%0d edge %0d: rs=%h cd=%h want 01 ff",
                     lv[i], n, row_sel, col_data);
          end
        end
        if (n == last_on + 1 && n <= 18) begin
          n_tests++;
          if (col_data !== 8'h00 || row_sel !== 8'h01) begin
            n_fail++;
            $display("FAIL pwm_off b=%0d edge %0d: rs=%h cd=%h want 01 00",
                     lv[i], n, row_sel, col_data);
          end
        end
      end
    end
  endtask

  task automatic test_bright_change();
    gd = '1;
    br = 3'd7;
    en = 1'b1;
    do_reset();
    for (int n = 1; n <= 40; n++) begin
      if (n == 10) br = 3'd0;
      step();
      n_tests++;
      if ({row_sel, col_data, row_idx, frame_start} !== {e_rs, e_cd, e_ri, e_fs}) begin
        n_fail++;
        $display("FAIL bchg edge %0d: rs=%h cd=%h want rs=%h cd=%h",
                 n, row_sel, col_data, e_rs, e_cd);
      end
      if (n == 18 || n == 22) begin
        n_tests++;
        if (col_data !== 8'hFF) begin
          n_fail++;
          $display("FAIL bchg_on edge %0d: cd=%h want ff", n, col_data);
        end
      end
      if (n == 23) begin
        n_tests++;
        if (col_data !== 8'h00 || row_sel !== 8'h02) begin
          n_fail++;
          $display("FAIL bchg_off edge 23: rs=%h cd=%h want 02 00", row_sel, col_data);
        end
      end
    end
  endtask

  task automatic test_enable();
    gd = {$urandom, $urandom};
    br = 3'($urandom_range(0, 7));
    en = 1'b1;
    do_reset();
    for (int n = 1; n <= 90; n++) begin
      if (n == 80) en = 1'b0;
      if (n == 86) begin
        en = 1'b1;
        gd = {$urandom, $urandom};
      end
      step();
      n_tests++;
      if ({row_sel, col_data, row_idx, frame_start} !== {e_rs, e_cd, e_ri, e_fs}) begin
        n_fail++;
        $display("FAIL enable edge %0d: rs=%h cd=%h ri=%0d fs=%b want rs=%h cd=%h ri=%0d fs=%b",
                 n, row_sel, col_data, row_idx, frame_start, e_rs, e_cd, e_ri, e_fs);
      end
      if (n == 80) begin
        n_tests++;
        if (row_sel !== 8'h00 || col_data !== 8'h00) begin
          n_fail++;
          $display("FAIL en_off edge 80: rs=%h cd=%h want 00 00", row_sel, col_data);
        end
      end
      if (n == 86) begin
        n_tests++;
        if (frame_start !== 1'b1) begin
          n_fail++;
          $display("FAIL en_fs: fs=%b want 1", frame_start);
        end
      end
      if (n == 88) begin
        n_tests++;
        if (row_sel !== 8'h01) begin
          n_fail++;
          $display("FAIL en_row0: rs=%h want 01", row_sel);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    gd = 64'h8040201008040201;
    br = 3'd7;
    en = 1'b1;
    do_reset();
    for (int n = 1; n <= 60; n++) step();
    n_tests++;
    if (row_sel !== 8'h08 || col_data !== 8'h08) begin
      n_fail++;
      $display("FAIL arst_pre: rs=%h cd=%h want 08 08", row_sel, col_data);
    end
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({row_sel, col_data, row_idx, frame_start} !== 20'h0) begin
      n_fail++;
      $display("FAIL arst_mid: rs=%h cd=%h ri=%0d fs=%b want all 0",
               row_sel, col_data, row_idx, frame_start);
    end
    do_reset();
    for (int n = 1; n <= 40; n++) begin
      step();
      n_tests++;
      if ({row_sel, col_data, row_idx, frame_start} !== {e_rs, e_cd, e_ri, e_fs}) begin
        n_fail++;
        $display("FAIL arst_after edge %0d: rs=%h cd=%h ri=%0d fs=%b want rs=%h cd=%h ri=%0d fs=%b",
                 n, row_sel, col_data, row_idx, frame_start, e_rs, e_cd, e_ri, e_fs);
      end
      if (n == 3) begin
        n_tests++;
        if (row_sel !== 8'h01 || col_data !== 8'h01) begin
          n_fail++;
          $display("FAIL arst_row0: rs=%h cd=%h want 01 01", row_sel, col_data);
        end
      end
    end
  endtask

  task automatic test_random();
    gd = {$urandom, $urandom};
    br = 3'($urandom_range(0, 7));
    en = 1'b1;
    do_reset();
    for (int n = 1; n <= 4 * F; n++) begin
      if ($urandom_range(0, 15) == 0) br = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) gd = {$urandom, $urandom};
      if ($urandom_range(0, 199) == 0) en = ~en;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      step();
      n_tests++;
      if ({row_sel, col_data, row_idx, frame_start} !== {e_rs, e_cd, e_ri, e_fs}) begin
        n_fail++;
        $display("FAIL random cyc %0d: rs=%h cd=%h ri=%0d fs=%b want rs=%h cd=%h ri=%0d fs=%b",
                 n, row_sel, col_data, row_idx, frame_start, e_rs, e_cd, e_ri, e_fs);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    br  = 3'd0;
    gd  = '0;
    test_reset();
    test_basic();
    test_tear();
    test_pwm();
    test_bright_change();
    test_enable();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_matrix_scan.md
Name: led_matrix_scan

Overview:
- Downstream consumer of the stacker game's 64-bit game_display frame.
- Time-multiplexes the frame onto the 8x8 LED matrix, one row at a time, with a blanking gap between rows (anti-ghosting) and 8-level PWM brightness.
- Double-buffers the frame at frame boundaries so game updates never tear mid-scan.

Parameters:
- DWELL_CYCLES, 1000: cycles a row is driven; must be a multiple of 8 and >= 8.
- BLANK_CYCLES, 4: cycles with all rows off before each row; must be >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- game_display  input  64  frame; row r = bits [8r+7:8r]; column c = bit c of that byte
- enable  input  1  scan enable, synchronous
- brightness  input  3  0 = 1/8 duty, 7 = full duty
- row_sel  output  8  one-hot row drive, active-high; 0 during blank
- col_data  output  8  column drive, active-high
- row_idx  output  3  row currently in its blank or dwell period
- frame_start  output  1  one-cycle pulse when the shadow frame is latched

Behaviour:
- Reset (rst low): takes effect immediately, with no clock edge required.
  - Outputs: row_sel = 0, col_data = 0, row_idx = 0, frame_start = 0.
  - Internal state: shadow frame = 0; row counter and cycle counter = 0; latched brightness = 0.
- All outputs are registered.
- Timing is counted in rising edges after reset release with enable = 1. Edge n is the nth such edge.
- Row period P = BLANK_CYCLES + DWELL_CYCLES. Frame period F = 8*P.
- States per row:
  - BLANK, cycle counter 0..BLANK_CYCLES-1: row_sel = 0, col_data = 0.
  - DWELL, cycle counter BLANK_CYCLES..P-1: row_sel = 1 << row_idx; col_data = shadow[row_idx] gated by PWM.
- After the last DWELL cycle of a row:
  - row_idx increments, wrapping 7 -> 0.
  - The next row starts in BLANK.
- Frame latch: on the first BLANK cycle of row 0 (edge 1, then every F edges):
  - shadow <= game_display.
  - frame_start = 1 for exactly that cycle.
  - game_display is ignored at all other times.
- Brightness latch: brightness is sampled on the first BLANK cycle of every row. A mid-row change affects the next row only.
- PWM:
  - slot = (DWELL cycle offset) / (DWELL_CYCLES/8), giving values 0..7.
  - col_data = shadow row byte when slot <= latched brightness, else 0.
  - row_sel stays asserted for the whole DWELL regardless of PWM.
- enable low, sampled on an edge:
  - At that edge: outputs go to their reset values and counters clear to row 0, cycle 0.
  - The shadow frame is retained.
  - When enable rises again, the first edge with enable = 1 is treated as edge 1: new latch and frame_start pulse.
- Reset asserted mid-row or mid-frame: all outputs clear asynchronously. Scanning restarts at edge 1 after release.
- No cycle ever has more than one row_sel bit set.
- row_sel is 0 in the cycle where the row changes (guaranteed by BLANK_CYCLES >= 1).

Test Plan:
All scenarios use DWELL_CYCLES = 16, BLANK_CYCLES = 2 (P = 18, F = 144).
1. Reset, enable = 1, brightness = 7, game_display = 64'h8040201008040201 -> frame_start = 1 at edge 1 only.
   - Edges 1-2: row_sel = 0.
   - Edges 3-18: row_sel = 8'h01, col_data = 8'h01.
   - Edges 21-36: row_sel = 8'h02, col_data = 8'h02.
   - Next frame_start at edge 145.
2. Change game_display to all ones at edge 50 -> col_data keeps the old row bytes through edge 144. From edge 147, row 0 shows col_data = 8'hFF.
3. Row 0 = 8'hFF, brightness = 0 -> col_data = 8'hFF only on edges 3-4, 0 on edges 5-18.
   - brightness = 3 -> 8'hFF on edges 3-10.
   - brightness = 7 -> 8'hFF on edges 3-18.
4. Brightness 7 -> 0 at edge 10 -> row 0 stays full duty through edge 18. Row 1 is driven only on edges 21-22.
5. Deassert enable at edge 80 (row 4) -> row_sel = 0 and col_data = 0 from edge 80.
   - Reassert -> frame_start pulses on the first enabled edge.
   - row_sel = 8'h01 two edges later.
6. Assert rst low between edges in a row-3 DWELL -> row_sel, col_data, row_idx and frame_start all read 0 before the next clock edge.
   - After release, behaviour matches scenario 1 from edge 1.
